sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Sequencing controller for the 32x16 dual-word-line SRAM bank.
- Arbitrates two requesters (r0: fetch side, r1: datapath side) onto the array's word_a/word_b one-hot lines, read_en, write_en and shared write-data bus.
- Captures array read data and returns it with a done pulse.
- Two reads go out in parallel, one per word line. Writes are exclusive because the array writes both selected rows from one data bus.

Parameters:
ADDR_W, 5, address width; DEPTH = 2**ADDR_W rows (32)
DATA_W, 16, word width

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  r0 request; held with its fields until gnt0
we0  in  1  r0 op: 1=write, 0=read
addr0  in  ADDR_W  r0 row address
wdata0  in  DATA_W  r0 write data
gnt0  out  1  r0 accept pulse, 1 cycle
done0  out  1  r0 completion pulse, 1 cycle
rdata0  out  DATA_W  r0 read data, valid with done0 for reads, held until next r0 read completes
req1, we1, addr1, wdata1, gnt1, done1, rdata1: same for r1
word_a  out  DEPTH  one-hot row select, array port A
word_b  out  DEPTH  one-hot row select, array port B
read_en  out  1  array read enable
write_en  out  1  array write enable
wr_data  out  DATA_W  array write data bus
arr_out_a  in  DATA_W  array port A read data
arr_out_b  in  DATA_W  array port B read data

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; prio=0 (r0 favoured). Reset mid-operation drops the in-flight op, issues no done, and clears word lines and enables immediately (asynchronous).
- FSM states: IDLE, ACCESS, COMPLETE.
- Accept is legal in IDLE or COMPLETE. Requests are sampled at the rising edge.
  - Accept with >=1 grant -> ACCESS; otherwise -> IDLE.
  - ACCESS -> COMPLETE unconditionally.
- Grant rules, evaluated in the accept cycle:
  - Only one req: grant it.
  - Both reads: grant both. r0 is routed to word_a, r1 to word_b.
  - Any write involved in a conflict: grant only the requester selected by prio, then flip prio to the other requester. The loser keeps req high and retries.
  - prio changes only on a conflict grant.
- gntN pulses in the accept cycle. The op is latched into internal registers (op, one-hot row, data) on the same edge.
- ACCESS cycle (T+1):
  - Read: read_en=1. word_a=onehot(addr of the r0 read or the sole read); word_b=onehot(r1 read addr), or a copy of word_a for a single read. Never all-zero, because all-zero decodes to row 0.
  - Write: write_en=1, word_a=word_b=onehot(addr), wr_data=wdata.
  - read_en and write_en are never asserted together.
  - Outside ACCESS: word lines are 0, enables 0, wr_data 0.
- COMPLETE cycle (T+2):
  - Registered capture on the ACCESS->COMPLETE edge: rdata from arr_out_a for the word_a owner, arr_out_b for the word_b owner.
  - doneN=1 for each granted requester during COMPLETE.
- Latency: gnt at T, array access at T+1, done/rdata at T+2. Peak throughput is one accept per 2 cycles.
- Address width: onehot = 1 << addr, DEPTH bits. Every address 0..31 is legal; there is no wrap.
- Same-address r0 read + r1 read: both granted, both return identical data.
- Read after write to the same row, issued back-to-back: returns the new data, because the write completes in ACCESS before the next ACCESS.
- Requester drops req before gnt: the request is ignored, no error.

Decomposition:
- Shared package sram_pkg holds:
  - ADDR_W, DATA_W, DEPTH constants
  - state enum {IDLE, ACCESS, COMPLETE}
  - op typedef struct {we, addr, data}
- One natural sub-module: sram_onehot_enc (ADDR_W -> DEPTH one-hot encoder), instantiated twice for word_a and word_b.

Test Plan:
1. Reset with rst_n=0 mid-ACCESS -> word_a=word_b=0, read_en=write_en=0, gnt/done=0 immediately; FSM returns to IDLE.
2. r0 write addr=3 data=0xBEEF, then r1 read addr=3:
   - Write: gnt0 at T; at T+1 write_en=1, word_a=word_b=32'h8, wr_data=0xBEEF.
   - Read: done1 at its T+2 with rdata1=0xBEEF.
3. Simultaneous r0 read addr=5, r1 read addr=31 -> gnt0=gnt1 same cycle; word_a=32'h20, word_b=32'h8000_0000, read_en=1; done0=done1 at T+2 with the matching array data.
4. Both write continuously (r0 addr=1 data=0x1111, r1 addr=2 data=0x2222) from reset -> grants alternate r0,r1,r0,r1 every 2 cycles; write_en never overlaps read_en.
5. r0 write addr=0 + r1 read addr=7 simultaneously, prio=1 -> r1 granted first (single read, word_b=word_a=32'h80), r0 granted at the next accept; row 0 is never written by the read.
6. Single r1 read addr=0 after row 0 holds 0x1234 -> word_a=word_b=32'h1, rdata1=0x1234, done0 stays 0.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and types for the SRAM port arbiter
package sram_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester and array signals of the SRAM port arbiter
interface sram_port_arbiter_if;
  import sram_pkg::*;

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  logic [DEPTH-1:0]  word_a;
  logic [DEPTH-1:0]  word_b;
  logic              read_en;
  logic              write_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] arr_out_a;
  logic [DATA_W-1:0] arr_out_b;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output arr_out_a, arr_out_b,
    input  gnt0, done0, rdata0,
    input  gnt1, done1, rdata1,
    input  word_a, word_b, read_en, write_en, wr_data
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  arr_out_a, arr_out_b,
    output gnt0, done0, rdata0,
    output gnt1, done1, rdata1,
    output word_a, word_b, read_en, write_en, wr_data
  );

endinterface

// File: rtl/sram_onehot_enc.sv
// rtl/sram_onehot_enc.sv - row address to one-hot word-line encoder
module sram_onehot_enc
  import sram_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  onehot
);

  assign onehot = DEPTH'(1) << addr;

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester sequencing controller for the dual-word-line SRAM bank
module sram_port_arbiter
  import sram_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  sram_port_arbiter_if.slave bus
);

  state_t            state;
  state_t            next_state;
  logic              prio;
  logic              grant0;
  logic              grant1;
  logic              conflict;
  logic              accept_st;
  logic              in_access;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic              own0_q;
  logic              own1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DEPTH-1:0]  row_a;
  logic [DEPTH-1:0]  row_b;

  assign accept_st = (state == IDLE) || (state == COMPLETE);
  assign in_access = (state == ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A write anywhere in a double request forces a single grant chosen by prio.
  always_comb begin
    next_state = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    conflict   = 1'b0;
    case (state)
      IDLE, COMPLETE: begin
        conflict = bus.req0 && bus.req1 && (bus.we0 || bus.we1);
        if (conflict) begin
          grant0 = !prio;
          grant1 = prio;
        end else begin
          grant0 = bus.req0;
          grant1 = bus.req1;
        end
        next_state = (grant0 || grant1) ? ACCESS : IDLE;
      end
      ACCESS:  next_state = COMPLETE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio     <= 1'b0;
      op_q     <= '0;
      addr_b_q <= '0;
      own0_q   <= 1'b0;
      own1_q   <= 1'b0;
    end else if (accept_st) begin
      if (conflict) begin
        prio <= !prio;
      end
      own0_q <= grant0;
      own1_q <= grant1;
      if (grant0) begin
        op_q <= '{we: bus.we0, addr: bus.addr0, data: bus.wdata0};
      end else begin
        op_q <= '{we: bus.we1, addr: bus.addr1, data: bus.wdata1};
      end
      // Port B copies port A unless r1 shares the access; an idle line would select row 0.
      addr_b_q <= grant1 ? bus.addr1 : bus.addr0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (in_access && !op_q.we) begin
      if (own0_q) begin
        rdata0_q <= bus.arr_out_a;
      end
      if (own1_q) begin
        rdata1_q <= own0_q ? bus.arr_out_b : bus.arr_out_a;
      end
    end
  end

  sram_onehot_enc u_enc_a (
    .addr   (op_q.addr),
    .onehot (row_a)
  );

  sram_onehot_enc u_enc_b (
    .addr   (addr_b_q),
    .onehot (row_b)
  );

  // Grants are combinational from req, so they are masked while reset is held.
  assign bus.gnt0     = grant0 && rst_n;
  assign bus.gnt1     = grant1 && rst_n;
  assign bus.done0    = (state == COMPLETE) && own0_q;
  assign bus.done1    = (state == COMPLETE) && own1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.word_a   = in_access ? row_a : '0;
  assign bus.word_b   = in_access ? row_b : '0;
  assign bus.read_en  = in_access && !op_q.we;
  assign bus.write_en = in_access && op_q.we;
  assign bus.wr_data  = (in_access && op_q.we) ? op_q.data : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed vector bench for sram_port_arbiter
module tb_sram_port_arbiter;
  import sram_pkg::*;

  typedef struct {
    logic        req0;
    logic        we0;
    logic [4:0]  addr0;
    logic [15:0] wdata0;
    logic        req1;
    logic        we1;
    logic [4:0]  addr1;
    logic [15:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        read_en;
    logic        write_en;
    logic [31:0] word_a;
    logic [31:0] word_b;
    logic [15:0] wr_data;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_load = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [24];

  always #5 clk = ~clk;

  sram_port_arbiter_if bus ();

  sram_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic int row_of(input logic [DEPTH-1:0] w);
    for (int i = 0; i < DEPTH; i++) begin
      if (w[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (bus.write_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.word_a[i] || bus.word_b[i]) mem[i] <= bus.wr_data;
      end
    end
  end

  always_comb begin
    bus.arr_out_a = bus.read_en ? mem[row_of(bus.word_a)] : '0;
    bus.arr_out_b = bus.read_en ? mem[row_of(bus.word_b)] : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0   = v.req0;
    bus.we0    = v.we0;
    bus.addr0  = v.addr0;
    bus.wdata0 = v.wdata0;
    bus.req1   = v.req1;
    bus.we1    = v.we1;
    bus.addr1  = v.addr1;
    bus.wdata1 = v.wdata1;
  endtask

  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;

    //          r0: req we addr data      r1: req we addr data     | g0 g1 d0 d1 rd wr  word_a        word_b        wr_data   rdata0    rdata1
    vecs[0]  = '{1, 1, 3, 16'hBEEF, 0, 0, 0,  16'h0,    1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        16'h0,    16'h0,    16'h0};
    vecs[1]  = '{0, 0, 0, 16'h0,    1, 0, 3,  16'h0,    0, 0, 0, 0, 0, 1, 32'h8,        32'h8,        16'hBEEF, 16'h0,    16'h0};
    vecs[2]  = '{0, 0, 0, 16'h0,    1, 0, 3,  16'h0,    0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        16'h0,    16'h0,    16'h0};
    vecs[3]  = '{1, 0, 5, 16'h0,    1, 0, 31, 16'h0,    0, 0, 0, 0, 1, 0, 32'h8,        32'h8,        16'h0,    16'h0,    16'h0};
    vecs[4]  = '{1, 0, 5, 16'h0,    1, 0, 31, 16'h0,    1, 1, 0, 1, 0, 0, 32'h0,        32'h0,        16'h0,    16'h0,    16'hBEEF};
    vecs[5]  = '{0, 0, 0, 16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 1, 0, 32'h20,       32'h8000_0000, 16'h0,   16'h0,    16'hBEEF};
    vecs[6]  = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 1, 0, 1, 1, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'hA01F};
    vecs[7]  = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 0, 0, 0, 0, 0, 1, 32'h2,        32'h2,        16'h1111, 16'hA005, 16'hA01F};
    vecs[8]  = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'hA01F};
    vecs[9]  = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 0, 0, 0, 0, 0, 1, 32'h4,        32'h4,        16'h2222, 16'hA005, 16'hA01F};
    vecs[10] = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 1, 0, 0, 1, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'hA01F};
    vecs[11] = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 0, 0, 0, 0, 0, 1, 32'h2,        32'h2,        16'h1111, 16'hA005, 16'hA01F};
    vecs[12] = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'hA01F};
    vecs[13] = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 0, 0, 0, 0, 0, 1, 32'h4,        32'h4,        16'h2222, 16'hA005, 16'hA01F};
    vecs[14] = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 1, 0, 0, 1, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'hA01F};
    vecs[15] = '{1, 1, 1, 16'h1111, 1, 1, 2,  16'h2222, 0, 0, 0, 0, 0, 1, 32'h2,        32'h2,        16'h1111, 16'hA005, 16'hA01F};
    vecs[16] = '{1, 1, 0, 16'h1234, 1, 0, 7,  16'h0,    0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'hA01F};
    vecs[17] = '{1, 1, 0, 16'h1234, 0, 0, 0,  16'h0,    0, 0, 0, 0, 1, 0, 32'h80,       32'h80,       16'h0,    16'hA005, 16'hA01F};
    vecs[18] = '{1, 1, 0, 16'h1234, 0, 0, 0,  16'h0,    1, 0, 0, 1, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'hA007};
    vecs[19] = '{0, 0, 0, 16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 1, 32'h1,        32'h1,        16'h1234, 16'hA005, 16'hA007};
    vecs[20] = '{0, 0, 0, 16'h0,    1, 0, 0,  16'h0,    0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'hA007};
    vecs[21] = '{0, 0, 0, 16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 1, 0, 32'h1,        32'h1,        16'h0,    16'hA005, 16'hA007};
    vecs[22] = '{0, 0, 0, 16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'h1234};
    vecs[23] = '{0, 0, 0, 16'h0,    0, 0, 0,  16'h0,    0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        16'h0,    16'hA005, 16'h1234};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset gnt0", 32'(bus.gnt0), 0);
    check("reset gnt1", 32'(bus.gnt1), 0);
    check("reset done0", 32'(bus.done0), 0);
    check("reset done1", 32'(bus.done1), 0);
    check("reset read_en", 32'(bus.read_en), 0);
    check("reset write_en", 32'(bus.write_en), 0);
    check("reset word_a", bus.word_a, 0);
    check("reset word_b", bus.word_b, 0);
    check("reset wr_data", 32'(bus.wr_data), 0);
    check("reset rdata0", 32'(bus.rdata0), 0);
    check("reset rdata1", 32'(bus.rdata1), 0);
    mem_load = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("c%0d gnt0", i), 32'(bus.gnt0), 32'(vecs[i].gnt0));
      check($sformatf("c%0d gnt1", i), 32'(bus.gnt1), 32'(vecs[i].gnt1));
      check($sformatf("c%0d done0", i), 32'(bus.done0), 32'(vecs[i].done0));
      check($sformatf("c%0d done1", i), 32'(bus.done1), 32'(vecs[i].done1));
      check($sformatf("c%0d read_en", i), 32'(bus.read_en), 32'(vecs[i].read_en));
      check($sformatf("c%0d write_en", i), 32'(bus.write_en), 32'(vecs[i].write_en));
      check($sformatf("c%0d word_a", i), bus.word_a, vecs[i].word_a);
      check($sformatf("c%0d word_b", i), bus.word_b, vecs[i].word_b);
      check($sformatf("c%0d wr_data", i), 32'(bus.wr_data), 32'(vecs[i].wr_data));
      check($sformatf("c%0d rdata0", i), 32'(bus.rdata0), 32'(vecs[i].rdata0));
      check($sformatf("c%0d rdata1", i), 32'(bus.rdata1), 32'(vecs[i].rdata1));
      check($sformatf("c%0d en overlap", i), 32'(bus.read_en && bus.write_en), 0);
    end

    // Conflict write leaves prio=1, then reset lands in the middle of the access.
    @(posedge clk);
    #1;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 9;  bus.wdata0 = 16'h7777;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10; bus.wdata1 = 16'h8888;
    @(negedge clk);
    check("pre-reset gnt0", 32'(bus.gnt0), 1);
    check("pre-reset gnt1", 32'(bus.gnt1), 0);
    @(posedge clk);
    #1;
    check("pre-reset write_en", 32'(bus.write_en), 1);
    check("pre-reset word_a", bus.word_a, 32'h200);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-reset word_a", bus.word_a, 0);
    check("mid-reset word_b", bus.word_b, 0);
    check("mid-reset read_en", 32'(bus.read_en), 0);
    check("mid-reset write_en", 32'(bus.write_en), 0);
    check("mid-reset wr_data", 32'(bus.wr_data), 0);
    check("mid-reset gnt0", 32'(bus.gnt0), 0);
    check("mid-reset gnt1", 32'(bus.gnt1), 0);
    check("mid-reset done0", 32'(bus.done0), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset row9 untouched", 32'(mem[9]), 32'hA009);
    check("post-reset done0", 32'(bus.done0), 0);
    check("post-reset done1", 32'(bus.done1), 0);
    check("post-reset prio gnt0", 32'(bus.gnt0), 1);
    check("post-reset prio gnt1", 32'(bus.gnt1), 0);
    @(posedge clk);
    #1;
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
    check("post-reset write_en", 32'(bus.write_en), 1);
    check("post-reset wr_data", 32'(bus.wr_data), 32'h7777);
    check("post-reset access done0", 32'(bus.done0), 0);
    @(posedge clk);
    @(negedge clk);
    check("post-reset done0 pulse", 32'(bus.done0), 1);
    check("post-reset done1 quiet", 32'(bus.done1), 0);
    check("post-reset row9 written", 32'(mem[9]), 32'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
